hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It sits beside the operand-bypass unit and decides when the pipeline must stall, bubble or flush instead of forwarding. It covers three cases: load-use hazards, multi-cycle mul/div occupancy of EX, and taken-branch squash. It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage core.
// Decides stall / bubble / flush for load-use hazards, multi-cycle mul/div
// occupancy of EX and taken-branch squash, and keeps saturating stall and
// flush performance counters.
module hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FCNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        id_sel_rs1_i,
    input  logic [4:0]        id_sel_rs2_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_valid_i,
    input  logic              ex_is_load_i,
    input  logic [4:0]        ex_sel_rd_i,
    input  logic              ex_md_start_i,
    input  logic              md_done_i,
    input  logic              ex_branch_taken_i,
    input  logic              perf_clr_i,
    output logic              stall_pc_o,
    output logic              stall_if_id_o,
    output logic              stall_id_ex_o,
    output logic              flush_if_id_o,
    output logic              bubble_ex_o,
    output logic              bubble_mem_o,
    output logic              md_busy_o,
    output logic              md_timeout_o,
    output logic              protocol_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [FCNT_W-1:0] flush_cnt_o
);

    localparam int unsigned TW = $clog2(MD_TIMEOUT);
    localparam logic [TW-1:0] TLIM = TW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t            state_q;
    logic [TW-1:0]     tcnt_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [FCNT_W-1:0] flush_cnt_q;

    logic md_launch;
    logic load_use;
    logic flush_evt;

    assign md_launch = ex_md_start_i & ex_valid_i;
    assign load_use  = ex_valid_i & ex_is_load_i & (ex_sel_rd_i != 5'd0) &
                       ((id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i)) |
                        (id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i)));

    // Control outputs decoded from state and current inputs (act in the detect cycle)
    always_comb begin
        stall_pc_o     = 1'b0;
        stall_if_id_o  = 1'b0;
        stall_id_ex_o  = 1'b0;
        flush_if_id_o  = 1'b0;
        bubble_ex_o    = 1'b0;
        bubble_mem_o   = 1'b0;
        md_busy_o      = 1'b0;
        md_timeout_o   = 1'b0;
        protocol_err_o = 1'b0;
        flush_evt      = 1'b0;
        case (state_q)
            RUN: begin
                protocol_err_o = md_done_i;
                if (md_launch) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    stall_id_ex_o = 1'b1;
                    bubble_mem_o  = 1'b1;
                    if (ex_branch_taken_i) begin
                        protocol_err_o = 1'b1;
                    end
                end else if (ex_branch_taken_i & ex_valid_i) begin
                    flush_if_id_o = 1'b1;
                    bubble_ex_o   = 1'b1;
                    flush_evt     = 1'b1;
                end else if (load_use) begin
                    stall_pc_o    = 1'b1;
                    stall_if_id_o = 1'b1;
                    bubble_ex_o   = 1'b1;
                end
            end
            MD_WAIT: begin
                md_busy_o = 1'b1;
                // md_done wins over the timeout when both land in the same cycle
                if (!md_done_i) begin
                    if (tcnt_q == TLIM) begin
                        md_timeout_o = 1'b1;
                    end else begin
                        stall_pc_o    = 1'b1;
                        stall_if_id_o = 1'b1;
                        stall_id_ex_o = 1'b1;
                        bubble_mem_o  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // FSM state and MD_WAIT timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (md_launch) begin
                        state_q <= MD_WAIT;
                        tcnt_q  <= '0;
                    end
                end
                MD_WAIT: begin
                    if (md_done_i || (tcnt_q == TLIM)) begin
                        state_q <= RUN;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Saturating performance counters; clear overrides increment
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_pc_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_hazard_ctrl;

    localparam int MDT = 4;
    localparam int CW  = 8;
    localparam int FW  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [4:0]    id_sel_rs1_i, id_sel_rs2_i, ex_sel_rd_i;
    logic          id_uses_rs1_i, id_uses_rs2_i, ex_valid_i, ex_is_load_i;
    logic          ex_md_start_i, md_done_i, ex_branch_taken_i, perf_clr_i;
    logic          stall_pc_o, stall_if_id_o, stall_id_ex_o, flush_if_id_o;
    logic          bubble_ex_o, bubble_mem_o, md_busy_o, md_timeout_o, protocol_err_o;
    logic [CW-1:0] stall_cnt_o;
    logic [FW-1:0] flush_cnt_o;

    hazard_ctrl #(.MD_TIMEOUT(MDT), .CNT_W(CW), .FCNT_W(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_sel_rs1_i(id_sel_rs1_i), .id_sel_rs2_i(id_sel_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_valid_i(ex_valid_i), .ex_is_load_i(ex_is_load_i), .ex_sel_rd_i(ex_sel_rd_i),
        .ex_md_start_i(ex_md_start_i), .md_done_i(md_done_i),
        .ex_branch_taken_i(ex_branch_taken_i), .perf_clr_i(perf_clr_i),
        .stall_pc_o(stall_pc_o), .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
        .flush_if_id_o(flush_if_id_o), .bubble_ex_o(bubble_ex_o), .bubble_mem_o(bubble_mem_o),
        .md_busy_o(md_busy_o), .md_timeout_o(md_timeout_o), .protocol_err_o(protocol_err_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    int total = 0;
    int bad   = 0;
    int to_seen = 0;
    int perr_seen = 0;

    // behavioural model: "waiting" flag, cycles spent waiting, plain int counters
    logic m_wait = 1'b0;
    int   m_cnt = 0, m_stall = 0, m_flush = 0;
    logic e_spc, e_sifid, e_sidex, e_fl, e_bex, e_bmem, e_busy, e_to, e_perr;
    logic e_start, e_flevt;

    always @(negedge clk) begin
        if (md_timeout_o === 1'b1) to_seen++;
        if (protocol_err_o === 1'b1) perr_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_comb();
        logic lu;
        {e_spc, e_sifid, e_sidex, e_fl, e_bex, e_bmem, e_to, e_perr, e_start, e_flevt} = '0;
        e_busy = m_wait;
        if (!m_wait) begin
            e_start = ex_valid_i && ex_md_start_i;
            lu = ex_valid_i && ex_is_load_i && (ex_sel_rd_i != 0) &&
                 ((id_uses_rs1_i && id_sel_rs1_i == ex_sel_rd_i) ||
                  (id_uses_rs2_i && id_sel_rs2_i == ex_sel_rd_i));
            e_perr = md_done_i || (e_start && ex_branch_taken_i);
            if (e_start) begin
                e_spc = 1; e_sifid = 1; e_sidex = 1; e_bmem = 1;
            end else if (ex_valid_i && ex_branch_taken_i) begin
                e_fl = 1; e_bex = 1; e_flevt = 1;
            end else if (lu) begin
                e_spc = 1; e_sifid = 1; e_bex = 1;
            end
        end else if (!md_done_i) begin
            if (m_cnt == MDT - 1) e_to = 1;
            else begin
                e_spc = 1; e_sifid = 1; e_sidex = 1; e_bmem = 1;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_wait = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (perf_clr_i) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (e_spc && m_stall < (1 << CW) - 1) m_stall++;
                if (e_flevt && m_flush < (1 << FW) - 1) m_flush++;
            end
            if (!m_wait) begin
                if (e_start) begin m_wait = 1; m_cnt = 0; end
            end else if (md_done_i || m_cnt == MDT - 1) m_wait = 0;
            else m_cnt++;
        end
    endtask

    task automatic check_model();
        chk("stall_pc",     32'(stall_pc_o),     32'(e_spc));
        chk("stall_if_id",  32'(stall_if_id_o),  32'(e_sifid));
        chk("stall_id_ex",  32'(stall_id_ex_o),  32'(e_sidex));
        chk("flush_if_id",  32'(flush_if_id_o),  32'(e_fl));
        chk("bubble_ex",    32'(bubble_ex_o),    32'(e_bex));
        chk("bubble_mem",   32'(bubble_mem_o),   32'(e_bmem));
        chk("md_busy",      32'(md_busy_o),      32'(e_busy));
        chk("md_timeout",   32'(md_timeout_o),   32'(e_to));
        chk("protocol_err", 32'(protocol_err_o), 32'(e_perr));
        chk("stall_cnt",    32'(stall_cnt_o),    32'(m_stall));
        chk("flush_cnt",    32'(flush_cnt_o),    32'(m_flush));
    endtask

    task automatic step();
        model_comb();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        id_sel_rs1_i = '0; id_sel_rs2_i = '0; ex_sel_rd_i = '0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0; ex_valid_i = 0; ex_is_load_i = 0;
        ex_md_start_i = 0; md_done_i = 0; ex_branch_taken_i = 0; perf_clr_i = 0;
    endtask

    task automatic md_start();
        idle(); ex_valid_i = 1; ex_md_start_i = 1;
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic u1, u2, ev, ld, br, mdd;
        logic spc, sifid, bex, fl, perr;
    } vec_t;
    vec_t tab[10];

    initial begin
        tab[0] = '{5'd5,  5'd0, 5'd5,  1,0,1,1,0,0, 1,1,1,0,0};
        tab[1] = '{5'd0,  5'd0, 5'd0,  1,1,1,1,0,0, 0,0,0,0,0};
        tab[2] = '{5'd3,  5'd7, 5'd7,  1,0,1,1,0,0, 0,0,0,0,0};
        tab[3] = '{5'd3,  5'd7, 5'd7,  1,1,1,1,0,0, 1,1,1,0,0};
        tab[4] = '{5'd5,  5'd0, 5'd5,  1,0,0,1,0,0, 0,0,0,0,0};
        tab[5] = '{5'd5,  5'd0, 5'd5,  1,0,1,1,1,0, 0,0,1,1,0};
        tab[6] = '{5'd0,  5'd0, 5'd0,  0,0,0,0,0,1, 0,0,0,0,1};
        tab[7] = '{5'd9,  5'd9, 5'd9,  1,1,1,0,0,0, 0,0,0,0,0};
        tab[8] = '{5'd0,  5'd0, 5'd0,  0,0,0,0,1,0, 0,0,0,0,0};
        tab[9] = '{5'd31, 5'd4, 5'd31, 1,0,1,1,0,0, 1,1,1,0,0};

        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        model_edge();
        #1;
        rst_n = 1;
        chk("reset_busy", 32'(md_busy_o), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt_o), 32'd0);
        step();

        // single-cycle vectors from RUN
        for (int i = 0; i < 10; i++) begin
            idle();
            id_sel_rs1_i = tab[i].rs1; id_sel_rs2_i = tab[i].rs2; ex_sel_rd_i = tab[i].rd;
            id_uses_rs1_i = tab[i].u1; id_uses_rs2_i = tab[i].u2;
            ex_valid_i = tab[i].ev; ex_is_load_i = tab[i].ld;
            ex_branch_taken_i = tab[i].br; md_done_i = tab[i].mdd;
            model_comb();
            @(negedge clk);
            chk($sformatf("vec%0d_stall_pc", i),    32'(stall_pc_o),     32'(tab[i].spc));
            chk($sformatf("vec%0d_stall_if_id", i), 32'(stall_if_id_o),  32'(tab[i].sifid));
            chk($sformatf("vec%0d_bubble_ex", i),   32'(bubble_ex_o),    32'(tab[i].bex));
            chk($sformatf("vec%0d_flush", i),       32'(flush_if_id_o),  32'(tab[i].fl));
            chk($sformatf("vec%0d_perr", i),        32'(protocol_err_o), 32'(tab[i].perr));
            check_model();
            @(posedge clk);
            model_edge();
            #1;
        end

        // load-use then empty EX
        idle(); perf_clr_i = 1; step();
        idle(); ex_valid_i = 1; ex_is_load_i = 1; ex_sel_rd_i = 5; id_sel_rs1_i = 5; id_uses_rs1_i = 1;
        step();
        idle(); step();
        chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);

        // mul/div latency 3
        idle(); perf_clr_i = 1; step();
        md_start(); step();
        chk("md_busy_c1", 32'(md_busy_o), 32'd1);
        idle(); step();
        step();
        md_done_i = 1; step();
        idle();
        chk("md_release_busy", 32'(md_busy_o), 32'd0);
        chk("md_stall_cnt", 32'(stall_cnt_o), 32'd3);

        // timeout: no md_done
        to_seen = 0; perr_seen = 0;
        md_start(); step();
        idle();
        repeat (5) step();
        chk("timeout_pulses", 32'(to_seen), 32'd1);
        chk("timeout_busy", 32'(md_busy_o), 32'd0);
        md_done_i = 1; step();
        chk("late_done_perr", 32'(perr_seen), 32'd1);

        // branch + load-use, then branch + md_start
        idle(); perf_clr_i = 1; step();
        idle(); ex_valid_i = 1; ex_is_load_i = 1; ex_sel_rd_i = 6; id_sel_rs2_i = 6;
        id_uses_rs2_i = 1; ex_branch_taken_i = 1;
        step();
        chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt_o), 32'd0);
        perr_seen = 0;
        md_start(); ex_branch_taken_i = 1; step();
        chk("br_md_perr", 32'(perr_seen), 32'd1);
        chk("br_md_busy", 32'(md_busy_o), 32'd1);
        chk("br_md_flush_cnt", 32'(flush_cnt_o), 32'd1);
        idle(); md_done_i = 1; step();

        // reset in the second MD_WAIT cycle
        idle(); step();
        md_start(); step();
        idle(); step();
        to_seen = 0;
        rst_n = 0; step();
        rst_n = 1;
        chk("rst_wait_busy", 32'(md_busy_o), 32'd0);
        chk("rst_wait_stall_cnt", 32'(stall_cnt_o), 32'd0);
        chk("rst_wait_flush_cnt", 32'(flush_cnt_o), 32'd0);
        step();
        chk("rst_wait_no_timeout", 32'(to_seen), 32'd0);

        // flush counter saturation (narrow counter)
        idle(); ex_valid_i = 1; ex_branch_taken_i = 1;
        repeat ((1 << FW) + 2) step();
        chk("flush_sat", 32'(flush_cnt_o), 32'((1 << FW) - 1));
        perf_clr_i = 1; step();
        chk("clr_over_inc", 32'(flush_cnt_o), 32'd0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n            = ($urandom_range(0, 299) != 0);
            perf_clr_i       = ($urandom_range(0, 999) == 0);
            id_sel_rs1_i     = 5'($urandom_range(0, 3));
            id_sel_rs2_i     = 5'($urandom_range(0, 3));
            ex_sel_rd_i      = 5'($urandom_range(0, 3));
            id_uses_rs1_i    = 1'($urandom_range(0, 1));
            id_uses_rs2_i    = 1'($urandom_range(0, 1));
            ex_valid_i       = ($urandom_range(0, 3) != 0);
            ex_is_load_i     = 1'($urandom_range(0, 1));
            ex_md_start_i    = ($urandom_range(0, 7) == 0);
            md_done_i        = ($urandom_range(0, 5) == 0);
            ex_branch_taken_i = ($urandom_range(0, 3) == 0);
            step();
        end
        rst_n = 1;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
